hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the flush/stall side of the ID/EX control register and the other inter-stage registers of the 5-stage RISC-V core. It consumes the E/M/W-stage control outputs (ResultSrcE, RegWriteM/W, destination registers, branch resolution) and returns stall, clear and forwarding selects to the registers and operand muxes. It also sequences data-memory wait states through a handshake FSM with a timeout. It optionally carries hazard performance counters.

## Interface
- MEM_TIMEOUT, 255: number of consecutive not-ready cycles in WAIT before the error state is entered; legal range 1..65535.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in Execute.
- ResultSrcE  in  2  result select in Execute; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback.
- MemReqM  in  1  load or store active in Memory.
- MemReadyM  in  1  data-memory ack; the access completes in the cycle it is high.
- StallF, StallD, StallE, StallM  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1  clear the IF/ID, ID/EX and MEM/WB registers; FlushE drives the ID/EX `clear` input.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- MemErr  out  1  sticky timeout flag.
- StallCount, FlushCount  out  32  performance counters.

## Operation
- FSM states and transitions:
  - RUN to WAIT when MemReqM && !MemReadyM.
  - WAIT to RUN when MemReadyM.
  - WAIT to ERR when the wait counter reaches MEM_TIMEOUT-1 and MemReadyM is low.
  - ERR is left only by reset.
- Memory wait, memWait = (RUN or WAIT) && MemReqM && !MemReadyM:
  - asserts StallF, StallD, StallE, StallM and FlushW;
  - suppresses all load-use and branch outputs.
- ERR state: holds StallF, StallD, StallE, StallM and FlushW at 1 and sets MemErr=1.
- Load-use, lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D):
  - StallF=StallD=1 and FlushE=1.
- Control hazard: PCSrcE gives FlushD=1 and FlushE=1.
- Combined equations when not in memory wait: FlushE = lwStall | PCSrcE, FlushD = PCSrcE, StallE = StallM = FlushW = 0.
- Forwarding is purely combinational and evaluated in every state:
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - otherwise 00.
  - ForwardBE uses the same rule with Rs2E.
  - Memory beats Writeback when both match.
- Wait counter: cleared on entry to WAIT, increments each WAIT cycle with MemReadyM low; width is $clog2(MEM_TIMEOUT+1).

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the registered state, so zero-cycle latency. A stall is visible in the same cycle the hazard appears.
- State, wait counter, MemErr and the perf counters update on the rising edge of clk.
- The WAIT exit is same-cycle: MemReadyM high in WAIT drops the stalls in that cycle.
- While reset is high, and after reset:
  - state RUN, counter 0, MemErr 0;
  - StallCount and FlushCount 0;
  - all stall, flush and forward outputs 0, regardless of inputs.
- Reset takes effect mid-WAIT or in ERR on the next edge.
- Boundary cases:
  - MemReqM && MemReadyM in RUN: no stall, no state change.
  - A load-use hazard coinciding with memWait: only the memory stall is emitted, and the load-use condition is re-evaluated after release.
  - Rd of x0 never forwards and never causes a stall.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle FlushD|FlushE=1.
  - Both counters are 32-bit and saturate at 32'hFFFFFFFF.
- HAZARD_PERF_EN undefined: both counters are removed and StallCount and FlushCount are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - RESULT_LOAD=2'b01;
  - the state encoding RUN=2'b00, WAIT=2'b01, ERR=2'b10.
- One combinational sub-module, fwd_unit, is instantiated once with both operands' compares (Rs1E/Rs2E against RdM/RdW) and produces ForwardAE and ForwardBE.
- The FSM, stall/flush logic and counters live in hazard_ctrl.

## Test plan
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 and FlushD=0. Repeat with RdE=0 → all 0.
- Forwarding:
  - RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7 → ForwardAE=10.
  - Drop RegWriteM → ForwardAE=01.
  - Rs2E=7 → ForwardBE follows the same rule.
- Branch: PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → the four stalls and FlushW=1 for exactly 3 cycles, state back to RUN, PCSrcE ignored throughout.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → ERR entered, MemErr=1 persisting after MemReadyM=1. Reset clears MemErr and all outputs.
- Perf counters (HAZARD_PERF_EN): 2 load-use cycles plus 1 branch cycle → StallCount=2, FlushCount=3. Without the macro both read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and forwarding select rule for the hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE    = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } state_t;

  // Memory stage has the younger result, so it wins when both stages match.
  function automatic logic [1:0] fwd_sel(input logic       regwrite_m,
                                         input logic [4:0] rd_m,
                                         input logic       regwrite_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (regwrite_m && rd_m != 5'd0 && rd_m == rs)
      return FWD_MEM;
    else if (regwrite_w && rd_w != 5'd0 && rd_w == rs)
      return FWD_WB;
    else
      return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational operand forwarding selects for both ALU inputs in Execute.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control with a data-memory wait FSM and timeout.
// Optional hazard performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             memerr_q;
  logic             mem_wait, hold, lw_stall;
  logic [1:0]       fwd_a, fwd_b;

  fwd_unit u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwd_a),
    .ForwardBE (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      memerr_q <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      memerr_q <= memerr_q | (state_n == ERR);
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_n    = WAIT;
          wait_cnt_n = '0;
        end
      end
      WAIT: begin
        if (MemReadyM)
          state_n = RUN;
        else if (wait_cnt == CNT_LAST)
          state_n = ERR;
        else
          wait_cnt_n = wait_cnt + 1'b1;
      end
      ERR:     state_n = ERR;
      default: state_n = RUN;
    endcase
  end

  // A memory hold (wait or error) masks load-use and branch handling entirely.
  assign mem_wait = (state == RUN || state == WAIT) && MemReqM && !MemReadyM;
  assign hold     = mem_wait || (state == ERR);
  assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (!reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  assign MemErr = memerr_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, StallF);
      flush_cnt <= sat_inc(flush_cnt, FlushD | FlushE);
    end
  end

  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus wait/timeout/reset/perf sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemErr;
  logic [31:0] StallCount, FlushCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  typedef struct {
    string       name;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]  rsrc;
    logic        pcsrc, rwm, rww, req, rdy;
    logic [6:0]  ctl;
    logic [1:0]  fae, fbe;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mkv(string n, logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                               logic [1:0] rsrc, logic pcsrc, logic [4:0] rdm, rdw,
                               logic rwm, rww, req, rdy,
                               logic [6:0] ctl, logic [1:0] fae, fbe);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rsrc = rsrc; v.pcsrc = pcsrc; v.rdm = rdm; v.rdw = rdw;
    v.rwm = rwm; v.rww = rww; v.req = req; v.rdy = rdy;
    v.ctl = ctl; v.fae = fae; v.fbe = fbe;
    return v;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    ResultSrcE = v.rsrc; PCSrcE = v.pcsrc; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.rwm; RegWriteW = v.rww; MemReqM = v.req; MemReadyM = v.rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 name      rs1d rs2d rs1e rs2e rde rsrc pc rdm rdw rwm rww req rdy ctl         fae    fbe
    vecs[0]  = mkv("idle",      0,   0,   0,   0,   0,  2'b00, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00);
    vecs[1]  = mkv("lu_rs1",    5,   0,   0,   0,   5,  2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b1100010, 2'b00, 2'b00);
    vecs[2]  = mkv("lu_x0",     0,   0,   0,   0,   0,  2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00);
    vecs[3]  = mkv("lu_rs2",    1,   9,   0,   0,   9,  2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b1100010, 2'b00, 2'b00);
    vecs[4]  = mkv("nonload",   5,   0,   0,   0,   5,  2'b00, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00);
    vecs[5]  = mkv("fwd_mem",   0,   0,   7,   0,   0,  2'b00, 0, 7, 7, 1, 1, 0, 0, 7'b0000000, 2'b10, 2'b00);
    vecs[6]  = mkv("fwd_wb",    0,   0,   7,   0,   0,  2'b00, 0, 7, 7, 0, 1, 0, 0, 7'b0000000, 2'b01, 2'b00);
    vecs[7]  = mkv("fwd_b",     0,   0,   3,   7,   0,  2'b00, 0, 7, 7, 1, 1, 0, 0, 7'b0000000, 2'b00, 2'b10);
    vecs[8]  = mkv("fwd_x0",    0,   0,   0,   0,   0,  2'b00, 0, 0, 0, 1, 1, 0, 0, 7'b0000000, 2'b00, 2'b00);
    vecs[9]  = mkv("branch",    0,   0,   0,   0,   0,  2'b00, 1, 0, 0, 0, 0, 0, 0, 7'b0000110, 2'b00, 2'b00);
    vecs[10] = mkv("req_rdy",   0,   0,   4,   0,   0,  2'b00, 0, 2, 4, 1, 1, 1, 1, 7'b0000000, 2'b01, 2'b00);
    vecs[11] = mkv("lu_branch", 5,   0,   0,   0,   5,  2'b01, 1, 0, 0, 0, 0, 0, 0, 7'b1100110, 2'b00, 2'b00);

    // Reset held with every kind of hazard driven
    idle();
    reset = 1'b1;
    step(); step();
    Rs1D = 5; RdE = 5; ResultSrcE = 2'b01; PCSrcE = 1;
    Rs1E = 7; RdM = 7; RegWriteM = 1; MemReqM = 1; MemReadyM = 0;
    #1;
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    chk("rst_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
    chk("rst_err", 32'(MemErr), 32'd0);
    chk("rst_cnt", StallCount | FlushCount, 32'd0);
    step();
    idle();
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_ctl"}, 32'(ctl_now()), 32'(vecs[i].ctl));
      chk({vecs[i].name, "_fwd"}, {28'd0, ForwardAE, ForwardBE},
          {28'd0, vecs[i].fae, vecs[i].fbe});
      step();
    end

    // Memory wait of 3 cycles with a branch pending throughout
    idle();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("wait_c%0d", c), 32'(ctl_now()), 32'b1111001);
      step();
    end
    MemReadyM = 1;
    @(negedge clk);
    chk("wait_release", 32'(ctl_now()), 32'b0000110);
    step();
    idle();
    MemReqM = 1; MemReadyM = 1;
    @(negedge clk);
    chk("back_in_run", 32'(ctl_now()), 32'd0);
    step();

    // Load-use coinciding with memory wait, then re-evaluated on release
    idle();
    ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; MemReqM = 1; MemReadyM = 0;
    @(negedge clk);
    chk("lu_in_wait", 32'(ctl_now()), 32'b1111001);
    step();
    MemReadyM = 1;
    @(negedge clk);
    chk("lu_after_wait", 32'(ctl_now()), 32'b1100010);
    step();

    // Timeout: 1 RUN cycle + 4 WAIT cycles not ready -> ERR
    idle();
    MemReqM = 1; MemReadyM = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("to_err_c%0d", c), 32'(MemErr), 32'd0);
      step();
    end
    chk("to_err_set", 32'(MemErr), 32'd1);
    MemReqM = 0; MemReadyM = 1; PCSrcE = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("err_hold_c%0d", c), {24'd0, MemErr, ctl_now()}, {24'd0, 1'b1, 7'b1111001});
      step();
    end
    reset = 1'b1;
    #1;
    chk("err_rst_outs", 32'(ctl_now()), 32'd0);
    step();
    reset = 1'b0;
    chk("err_rst_flag", 32'(MemErr), 32'd0);
    idle();
    @(negedge clk);
    chk("err_rst_run", 32'(ctl_now()), 32'd0);
    step();

    // Perf counters: 2 load-use cycles then 1 branch cycle
    do_reset();
    idle();
    ResultSrcE = 2'b01; RdE = 6; Rs2D = 6;
    step(); step();
    idle();
    PCSrcE = 1;
    step();
    idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", StallCount, 32'd2);
    chk("perf_flush", FlushCount, 32'd3);
`else
    chk("perf_stall", StallCount, 32'd0);
    chk("perf_flush", FlushCount, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
